// File: rtl/fetch_queue.sv
// Decoupled fetch: owns the PC, one imem word per cycle into a DEPTH-entry queue; 1-cycle fetch-to-head latency.
// Fetch stalls when the queue is full and not draining; redirect flushes. FETCH_QUEUE_STATS_EN builds the stat counters.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_rd,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stat_fetched,
    output logic [31:0]              stat_flushed,
    output logic [31:0]              stat_full_cycles
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          space;
    logic          do_push;
    logic          do_pop;

    // A full queue can still accept a word when the head leaves in the same cycle.
    assign space   = (count < FULL) || (deq && instr_valid);
    assign do_push = space && !redirect;
    assign do_pop  = deq && instr_valid && !redirect;

    assign imem_a      = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem_instr[rd_ptr] : 32'h0000_0013;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : 32'h0000_0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= imem_rd;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched     <= '0;
            stat_flushed     <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (do_push)
                stat_fetched <= stat_fetched + 32'd1;
            if (redirect)
                stat_flushed <= stat_flushed + {{(31-AW){1'b0}}, count};
            if (count == FULL && !deq)
                stat_full_cycles <= stat_full_cycles + 32'd1;
        end
    end
`else
    assign stat_fetched     = 32'h0;
    assign stat_flushed     = 32'h0;
    assign stat_full_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus hand sequences for stats, flush and async reset.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [2:0]  count;
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
    logic [31:0] stat_full_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction memory model: word = ~address, so pc and instr can never be confused.
    assign imem_rd = ~imem_a;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .count(count),
        .stat_fetched(stat_fetched), .stat_flushed(stat_flushed),
        .stat_full_cycles(stat_full_cycles)
    );

    typedef struct {
        logic        rdr;
        logic [31:0] rpc;
        logic        dq;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic [31:0] ia;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic rdr, input logic [31:0] rpc, input logic dq,
                                input logic vld, input logic [31:0] pc, input logic [2:0] cnt,
                                input logic [31:0] ia);
        vec_t v;
        v.rdr = rdr; v.rpc = rpc; v.dq = dq; v.vld = vld; v.pc = pc; v.cnt = cnt; v.ia = ia;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        deq = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic vld, input logic [31:0] pc,
                            input logic [2:0] cnt, input logic [31:0] ia);
        chk({name, ".valid"}, {31'h0, instr_valid}, {31'h0, vld});
        chk({name, ".pc"},    instr_pc, vld ? pc : 32'h0);
        chk({name, ".instr"}, instr,    vld ? ~pc : 32'h0000_0013);
        chk({name, ".count"}, {29'h0, count}, {29'h0, cnt});
        chk({name, ".imem_a"}, imem_a, ia);
    endtask

    logic [31:0] flushed0;

    initial begin
        // inputs for one cycle -> expected head/count/imem_a after the edge
        tbl[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd1, 32'h4);
        tbl[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd2, 32'h8);
        tbl[2]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd3, 32'hC);
        tbl[3]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd4, 32'h10);
        tbl[4]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd4, 32'h10);
        tbl[5]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   3'd4, 32'h10);
        tbl[6]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   3'd4, 32'h14);
        tbl[7]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h8,   3'd4, 32'h18);
        tbl[8]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hC,   3'd4, 32'h1C);
        tbl[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10,  3'd4, 32'h20);
        tbl[10] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h14,  3'd4, 32'h24);
        tbl[11] = mk(1'b1, 32'h103, 1'b1, 1'b0, 32'h0, 3'd0, 32'h100);
        tbl[12] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 3'd1, 32'h104);
        tbl[13] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 3'd1, 32'h108);
        tbl[14] = mk(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 3'd0, 32'hFFFF_FFFC);
        tbl[15] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 3'd1, 32'h0);
        tbl[16] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   3'd1, 32'h4);
        tbl[17] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   3'd1, 32'h8);
        tbl[18] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 3'd0, 32'h200);
        tbl[19] = mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 3'd0, 32'h300);
        tbl[20] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 3'd1, 32'h304);
        tbl[21] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 3'd1, 32'h308);

        // Table run from a fresh reset
        do_reset();
        chk_head("reset", 1'b0, 32'h0, 3'd0, 32'h0);
        chk("reset.stat_fetched", stat_fetched, 32'h0);
        for (int i = 0; i < 22; i++) begin
            redirect    = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            deq         = tbl[i].dq;
            step();
            chk_head($sformatf("vec%0d", i), tbl[i].vld, tbl[i].pc, tbl[i].cnt, tbl[i].ia);
        end
        redirect = 1'b0;

        // Streaming from reset with deq held high: one new head per cycle, no gaps
        do_reset();
        deq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_head($sformatf("stream%0d", i), 1'b1, 32'(4 * i), 3'd1, 32'(4 * i + 4));
        end

        // Fill for 6 cycles: two cycles spent full without deq
        do_reset();
        deq = 1'b0;
        repeat (6) step();
        chk("fill.count", {29'h0, count}, 32'd4);
        chk("fill.stat_full_cycles", stat_full_cycles, STATS ? 32'd2 : 32'd0);
        chk("fill.stat_fetched", stat_fetched, STATS ? 32'd4 : 32'd0);

        // Flush of three entries
        do_reset();
        repeat (3) step();
        chk("flush3.count_before", {29'h0, count}, 32'd3);
        flushed0 = stat_flushed;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        chk_head("flush3", 1'b0, 32'h0, 3'd0, 32'h100);
        chk("flush3.stat_flushed", stat_flushed - flushed0, STATS ? 32'd3 : 32'd0);
        step();
        chk_head("flush3.target", 1'b1, 32'h100, 3'd1, 32'h104);

        // Asynchronous reset mid-cycle with two entries queued away from RESET_PC
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        repeat (2) step();
        chk_head("pre_arst", 1'b1, 32'h400, 3'd2, 32'h408);
        #3 reset = 1'b1;
        #2;
        chk_head("arst", 1'b0, 32'h0, 3'd0, 32'h0);
        chk("arst.stat_fetched", stat_fetched, 32'h0);
        #1 reset = 1'b0;
        step();
        chk_head("arst.restart", 1'b1, 32'h0, 3'd1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
